// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: loader > data > instruction, with an anti-starvation
// override for instruction fetch. One access per IDLE->ACCESS->WAIT->DONE round.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P_I    = 2'd1;
  localparam logic [1:0] P_D    = 2'd2;
  localparam logic [1:0] P_L    = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            r_state;
  logic [1:0]        r_win;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_starve;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata, r_l_rdata;
  logic              r_i_ack, r_d_ack, r_l_ack;
  logic [1:0]        w_grant;
  logic              w_active;

  // A starved fetch overrides the fixed priority order.
  always_comb begin
    w_grant = P_NONE;
    if (i_req && (r_starve >= STARVE_LIM)) w_grant = P_I;
    else if (l_req)                        w_grant = P_L;
    else if (d_req)                        w_grant = P_D;
    else if (i_req)                        w_grant = P_I;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_win     <= P_NONE;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_starve  <= 4'd0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_l_rdata <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_l_ack   <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_l_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant != P_NONE) begin
            r_win   <= w_grant;
            r_state <= S_ACCESS;
            case (w_grant)
              P_L: begin
                r_addr  <= l_addr;
                r_we    <= l_we;
                r_wdata <= l_wdata;
              end
              P_D: begin
                r_addr  <= d_addr;
                r_we    <= d_we;
                r_wdata <= d_wdata;
              end
              default: begin
                r_addr  <= i_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
              end
            endcase
          end
          if (!i_req || (w_grant == P_I)) r_starve <= 4'd0;
          else if (r_starve != 4'hF)      r_starve <= r_starve + 4'd1;
        end
        S_ACCESS: r_state <= S_WAIT;
        S_WAIT: begin
          r_state <= S_DONE;
          if (!r_we) begin
            case (r_win)
              P_I:     r_i_rdata <= mem_rdata;
              P_D:     r_d_rdata <= mem_rdata;
              P_L:     r_l_rdata <= mem_rdata;
              default: ;
            endcase
          end
          r_i_ack <= (r_win == P_I);
          r_d_ack <= (r_win == P_D);
          r_l_ack <= (r_win == P_L);
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory drive decodes straight from state so reset kills a write strobe at once.
  assign w_active  = (r_state == S_ACCESS) || (r_state == S_WAIT);
  assign mem_addr  = w_active ? r_addr : '0;
  assign mem_wdata = w_active ? r_wdata : '0;
  assign mem_we    = (r_state == S_ACCESS) && r_we;

  assign cpu_hold = l_req || ((r_win == P_L) && (r_state != S_IDLE));
  assign busy     = (r_state != S_IDLE);

  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign l_rdata = r_l_rdata;
  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign l_ack   = r_l_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single accesses plus
// hand sequences for contention, starvation, reset and back-to-back cases.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, l_req, l_we;
  logic [31:0] i_addr, d_addr, d_wdata, l_addr, l_wdata;
  logic [31:0] i_rdata, d_rdata, l_rdata;
  logic        i_ack, d_ack, l_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, cpu_hold, busy;

  int tests = 0;
  int fails = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_ack(l_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words return a fixed per-address pattern.
  logic [31:0] ram [0:255];
  bit          wr_valid [0:255];

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    case (idx)
      8'd4:    return 32'hDEADBEEF;
      8'd12:   return 32'hCAFEF00D;
      8'd1:    return 32'h0BADF00D;
      default: return {24'h5A5A5A, idx};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[9:2]]      <= mem_wdata;
      wr_valid[mem_addr[9:2]] <= 1'b1;
    end
    mem_rdata <= wr_valid[mem_addr[9:2]] ? ram[mem_addr[9:2]] : init_word(mem_addr[9:2]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  port;   // 0 instr, 1 data, 2 loader
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 9;
  vec_t        vecs [NV];
  logic [31:0] shadow [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    case (p)
      0:       return i_ack;
      1:       return d_ack;
      default: return l_ack;
    endcase
  endfunction

  function automatic logic other_ack(input int p);
    case (p)
      0:       return d_ack | l_ack;
      1:       return i_ack | l_ack;
      default: return i_ack | d_ack;
    endcase
  endfunction

  task automatic set_req(input int p, input logic v);
    case (p)
      0:       i_req = v;
      1:       d_req = v;
      default: l_req = v;
    endcase
  endtask

  task automatic drive(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    case (p)
      0: i_addr = addr;
      1: begin d_we = we; d_addr = addr; d_wdata = wd; end
      default: begin l_we = we; l_addr = addr; l_wdata = wd; end
    endcase
  endtask

  task automatic wait_ack(input int p, input int max, output int n, output int wc,
                          output int bc, output int oc);
    bit got;
    got = 0; n = 0; wc = 0; bc = 0; oc = 0;
    while (!got && n < max) begin
      tick();
      n++;
      if (mem_we) wc++;
      if (busy) bc++;
      if (other_ack(p)) oc++;
      if (ack_of(p)) got = 1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout port %0d: no ack within %0d cycles", p, max);
    end
  endtask

  initial begin
    int n, wc, bc, oc;
    int t_l, t_d, t_i, hold_err;
    int who [10];
    int when [10];
    int na;

    vecs[0] = '{2'd0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{2'd1, 1'b1, 32'h20, 32'h12345678, 32'h0};
    vecs[2] = '{2'd1, 1'b0, 32'h20, 32'h0,        32'h12345678};
    vecs[3] = '{2'd2, 1'b1, 32'h40, 32'hA5A5A5A5, 32'h0};
    vecs[4] = '{2'd0, 1'b0, 32'h40, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{2'd1, 1'b0, 32'h08, 32'h0,        32'h5A5A5A02};
    vecs[7] = '{2'd2, 1'b1, 32'h08, 32'h11223344, 32'h0};
    vecs[8] = '{2'd1, 1'b0, 32'h08, 32'h0,        32'h11223344};
    for (int k = 0; k < 3; k++) shadow[k] = 32'h0;

    rst = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; l_req = 1; l_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; l_addr = 0; l_wdata = 0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_acks", {i_ack, d_ack, l_ack}, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_l_rdata", l_rdata, 0);
    check("rst_hold_lreq1", cpu_hold, 1);
    l_req = 0;
    #1;
    check("rst_hold_lreq0", cpu_hold, 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].port, vecs[k].we, vecs[k].addr, vecs[k].wdata);
      set_req(vecs[k].port, 1'b1);
      wait_ack(vecs[k].port, 8, n, wc, bc, oc);
      set_req(vecs[k].port, 1'b0);
      check($sformatf("v%0d_latency", k), n, 3);
      check($sformatf("v%0d_mem_we_cycles", k), wc, {31'b0, vecs[k].we});
      check($sformatf("v%0d_busy_cycles", k), bc, 3);
      check($sformatf("v%0d_other_acks", k), oc, 0);
      if (!vecs[k].we) shadow[vecs[k].port] = vecs[k].exp_rdata;
      check($sformatf("v%0d_i_rdata", k), i_rdata, shadow[0]);
      check($sformatf("v%0d_d_rdata", k), d_rdata, shadow[1]);
      check($sformatf("v%0d_l_rdata", k), l_rdata, shadow[2]);
      tick();
      check($sformatf("v%0d_idle_busy", k), busy, 0);
      check($sformatf("v%0d_ack_clear", k), ack_of(vecs[k].port), 0);
    end

    // Simultaneous requests: loader, then data, then instruction.
    drive(2, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b0, 32'h20, 32'h0);
    drive(0, 1'b0, 32'h04, 32'h0);
    l_req = 1; d_req = 1; i_req = 1;
    #1;
    check("sim_hold_start", cpu_hold, 1);
    t_l = -1; t_d = -1; t_i = -1; hold_err = 0;
    for (int c = 1; c <= 20 && t_i < 0; c++) begin
      tick();
      if (l_ack) t_l = c;
      if (d_ack) t_d = c;
      if (i_ack) t_i = c;
      if (cpu_hold !== ((t_l < 0) || (t_l == c))) hold_err++;
      if (l_ack) l_req = 0;
      if (d_ack) d_req = 0;
      if (i_ack) i_req = 0;
    end
    tick();
    check("sim_l_ack_cycle", t_l, 3);
    check("sim_d_ack_cycle", t_d, 7);
    check("sim_i_ack_cycle", t_i, 11);
    check("sim_cpu_hold_errs", hold_err, 0);
    check("sim_l_rdata", l_rdata, 32'hDEADBEEF);
    check("sim_d_rdata", d_rdata, 32'h12345678);
    check("sim_i_rdata", i_rdata, 32'h0BADF00D);
    tick();

    // Starvation: data held continuously, fetch wins every fifth grant.
    drive(1, 1'b0, 32'h20, 32'h0);
    drive(0, 1'b0, 32'h10, 32'h0);
    d_req = 1; i_req = 1;
    na = 0;
    for (int c = 1; c <= 60 && na < 10; c++) begin
      tick();
      if (d_ack) begin who[na] = 1; when[na] = c; na++; end
      else if (i_ack) begin who[na] = 0; when[na] = c; na++; end
    end
    d_req = 0; i_req = 0;
    tick();
    check("starve_ack_count", na, 10);
    for (int k = 0; k < na; k++) begin
      check($sformatf("starve_grant%0d", k), who[k], ((k == 4) || (k == 9)) ? 0 : 1);
      if (k > 0) check($sformatf("starve_gap%0d", k), when[k] - when[k-1], 4);
    end
    tick();

    // Async reset while a read of 0x30 sits in WAIT.
    drive(0, 1'b0, 32'h30, 32'h0);
    i_req = 1;
    tick();
    tick();
    check("rstwait_busy_before", busy, 1);
    rst = 1;
    #1;
    check("rstwait_busy", busy, 0);
    check("rstwait_mem_addr", mem_addr, 0);
    check("rstwait_i_rdata", i_rdata, 0);
    tick();
    check("rstwait_no_ack0", i_ack, 0);
    tick();
    check("rstwait_no_ack1", i_ack, 0);
    rst = 0;
    wait_ack(0, 8, n, wc, bc, oc);
    i_req = 0;
    check("rstwait_retry_latency", n, 3);
    check("rstwait_retry_rdata", i_rdata, 32'hCAFEF00D);
    tick();

    // Async reset during ACCESS of a write: strobe drops, write is lost.
    drive(1, 1'b1, 32'h30, 32'hFFFFFFFF);
    d_req = 1;
    tick();
    check("rstwr_mem_we_on", mem_we, 1);
    rst = 1;
    #1;
    check("rstwr_mem_we_off", mem_we, 0);
    d_req = 0; d_we = 0;
    tick();
    rst = 0;
    drive(0, 1'b0, 32'h30, 32'h0);
    i_req = 1;
    wait_ack(0, 8, n, wc, bc, oc);
    i_req = 0;
    check("rstwr_lost_write", i_rdata, 32'hCAFEF00D);
    tick();

    // Back-to-back fetches with the request held across the ack.
    drive(0, 1'b0, 32'h10, 32'h0);
    i_req = 1;
    wait_ack(0, 8, n, wc, bc, oc);
    check("b2b_first_latency", n, 3);
    check("b2b_first_rdata", i_rdata, 32'hDEADBEEF);
    i_addr = 32'h04;
    wait_ack(0, 8, n, wc, bc, oc);
    i_req = 0;
    check("b2b_second_gap", n, 4);
    check("b2b_second_rdata", i_rdata, 32'h0BADF00D);
    tick();

    // Request dropped one cycle after grant still completes.
    drive(0, 1'b0, 32'h40, 32'h0);
    i_req = 1;
    tick();
    i_req = 0;
    wait_ack(0, 6, n, wc, bc, oc);
    check("drop_req_latency", n, 2);
    check("drop_req_rdata", i_rdata, 32'hA5A5A5A5);
    tick();
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
